// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions: field polynomial, inverter state encoding,
// squarer select codes and a bit-serial multiply helper.
package gf8_pkg;

    localparam logic [8:0] POLY = 9'h11B;

    typedef enum logic [2:0] {
        IDLE,
        S2,
        S3,
        S6,
        S7,
        FIN,
        DONE
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_SQ1  = 2'b01;
    localparam logic [1:0] SEL_SQ3  = 2'b11;

    // poly_low is the reduction term without the implicit x^8 bit
    function automatic logic [7:0] gf_mul_f(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] poly_low);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (poly_low & {8{x[7]}});
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf8_mul.sv
// Combinational GF(2^8) multiplier, reduced modulo POLY.
module gf8_mul
    import gf8_pkg::*;
#(
    parameter logic [8:0] POLY = gf8_pkg::POLY
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    assign p = gf_mul_f(a, b, POLY[7:0]);

endmodule

// File: rtl/gf8_sq.sv
// Cascaded GF(2^8) squarer: sel gives the number of successive squarings (0..3).
module gf8_sq
    import gf8_pkg::*;
#(
    parameter logic [8:0] POLY = gf8_pkg::POLY
) (
    input  logic [7:0] din,
    input  logic [1:0] sel,
    output logic [7:0] dout
);

    logic [7:0] sq1;
    logic [7:0] sq2;
    logic [7:0] sq3;

    assign sq1 = gf_mul_f(din, din, POLY[7:0]);
    assign sq2 = gf_mul_f(sq1, sq1, POLY[7:0]);
    assign sq3 = gf_mul_f(sq2, sq2, POLY[7:0]);

    always_comb begin
        dout = din;
        case (sel)
            2'b01:   dout = sq1;
            2'b10:   dout = sq2;
            2'b11:   dout = sq3;
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/itoh_tsujii_inv.sv
// GF(2^8) inverter: a^-1 = (a^(2^7-1))^2 via Itoh-Tsujii, addition chain {1,2,3,6,7}.
module itoh_tsujii_inv
    import gf8_pkg::*;
#(
    parameter int unsigned M    = 8,
    parameter logic [8:0]  POLY = gf8_pkg::POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] dout
);

    state_t     state;
    state_t     state_nx;
    logic [M-1:0] a_reg;
    logic [M-1:0] beta;
    logic [1:0] sq_sel;
    logic [M-1:0] sq_out;
    logic [M-1:0] mul_b;
    logic [M-1:0] mul_out;

    gf8_sq #(.POLY(POLY)) u_sq (
        .din  (beta),
        .sel  (sq_sel),
        .dout (sq_out)
    );

    gf8_mul #(.POLY(POLY)) u_mul (
        .a (sq_out),
        .b (mul_b),
        .p (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // S6 doubles the chain length (beta_3 -> beta_6), every other step extends it by one
    always_comb begin
        state_nx = state;
        sq_sel   = SEL_NONE;
        mul_b    = a_reg;
        case (state)
            IDLE: if (start) state_nx = S2;
            S2:   begin sq_sel = SEL_SQ1; state_nx = S3;  end
            S3:   begin sq_sel = SEL_SQ1; state_nx = S6;  end
            S6:   begin sq_sel = SEL_SQ3; mul_b = beta; state_nx = S7; end
            S7:   begin sq_sel = SEL_SQ1; state_nx = FIN; end
            FIN:  begin sq_sel = SEL_SQ1; state_nx = DONE; end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            beta  <= '0;
            dout  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg <= din;
                    beta  <= din;
                end
                S2, S3, S6, S7: beta <= mul_out;
                FIN:  dout <= sq_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itoh_tsujii_inv.sv
// Directed bench for itoh_tsujii_inv: known inverses, latency, ignored starts,
// async reset abort and a full operand sweep checked by multiplication.
module tb_itoh_tsujii_inv;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int nvec;
    int nfail;
    int done_pulses;

    itoh_tsujii_inv #(.M(8), .POLY(9'h11B)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_pulses++;

    // Reference multiply: peasant algorithm, reduce by 0x1B on carry out of bit 7
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        x = a;
        y = b;
        r = 8'h00;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            if (x[7]) x = (x << 1) ^ 8'h1B;
            else      x = x << 1;
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full inversion starting mid-cycle; checks every edge E0..E6
    task automatic do_inv(input string tag, input logic [7:0] a, input logic [7:0] exp);
        start = 1'b1;
        din   = a;
        tick();
        start = 1'b0;
        din   = 8'hA5;
        chk({tag, "_busy_e0"}, {7'd0, busy}, 8'd1);
        chk({tag, "_done_e0"}, {7'd0, done}, 8'd0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk({tag, "_busy_mid"}, {7'd0, busy}, 8'd1);
            chk({tag, "_done_mid"}, {7'd0, done}, 8'd0);
        end
        tick();
        chk({tag, "_done_e5"}, {7'd0, done}, 8'd1);
        chk({tag, "_busy_e5"}, {7'd0, busy}, 8'd1);
        chk({tag, "_dout"},    dout, exp);
        tick();
        chk({tag, "_done_e6"}, {7'd0, done}, 8'd0);
        chk({tag, "_busy_e6"}, {7'd0, busy}, 8'd0);
        chk({tag, "_dout_hold"}, dout, exp);
    endtask

    initial begin
        logic [7:0] tbl [14];
        int k;

        nvec        = 0;
        nfail       = 0;
        done_pulses = 0;
        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;

        #1;
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_dout", dout, 8'h00);

        // release between edges; start then lands on the first edge after release
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_inv("inv53", 8'h53, 8'hCA);
        do_inv("inv02", 8'h02, 8'h8D);
        do_inv("inv01", 8'h01, 8'h01);
        do_inv("inv00", 8'h00, 8'h00);

        // start pulsed while in S3 must not disturb the running 0x02 inversion
        start = 1'b1;
        din   = 8'h02;
        tick();
        start = 1'b0;
        din   = 8'h00;
        tick();
        start = 1'b1;
        din   = 8'h53;
        tick();
        start = 1'b0;
        tick();
        chk("s3start_done_e3", {7'd0, done}, 8'd0);
        tick();
        chk("s3start_done_e4", {7'd0, done}, 8'd0);
        tick();
        chk("s3start_done_e5", {7'd0, done}, 8'd1);
        chk("s3start_dout", dout, 8'h8D);
        tick();
        chk("s3start_busy_e6", {7'd0, busy}, 8'd0);
        tick();
        chk("s3start_noqueue", {7'd0, busy}, 8'd0);

        // start held high, din changes every cycle; only steps 0 and 7 are sampled
        tbl[0] = 8'h53;
        for (int i = 1; i < 14; i++) tbl[i] = 8'hFF;
        tbl[3]  = 8'h10;
        tbl[6]  = 8'h10;
        tbl[7]  = 8'h02;
        tbl[8]  = 8'h10;
        for (int i = 0; i < 14; i++) begin
            start = 1'b1;
            din   = tbl[i];
            tick();
            chk("held_busy", {7'd0, busy}, (i == 6 || i == 13) ? 8'd0 : 8'd1);
            if (i == 5) begin
                chk("held_done_a", {7'd0, done}, 8'd1);
                chk("held_dout_a", dout, 8'hCA);
            end else if (i == 12) begin
                chk("held_done_b", {7'd0, done}, 8'd1);
                chk("held_dout_b", dout, 8'h8D);
            end else begin
                chk("held_nodone", {7'd0, done}, 8'd0);
            end
        end
        start = 1'b0;
        tick();

        // async reset in S6, away from any clock edge
        start = 1'b1;
        din   = 8'h53;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        chk("arst_dout", dout, 8'h00);
        done_pulses = 0;
        tick();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        chk("arst_nopulse", done_pulses[7:0], 8'd0);
        do_inv("post_rst53", 8'h53, 8'hCA);

        // sweep: every nonzero operand times its result must equal 1
        done_pulses = 0;
        for (int a = 0; a < 256; a++) begin
            start = 1'b1;
            din   = a[7:0];
            tick();
            start = 1'b0;
            k = 0;
            while (!done && k < 8) begin
                tick();
                k++;
            end
            chk("sweep_lat", k[7:0], 8'd5);
            if (a == 0) chk("sweep_zero", dout, 8'h00);
            else        chk("sweep_inv", ref_mul(a[7:0], dout), 8'h01);
            tick();
        end
        #1;
        nvec++;
        assert (done_pulses == 256) else begin
            nfail++;
            $error("FAIL sweep_count: observed %0d expected 256", done_pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
